// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver: sync, glitch filter, framing, prefix decode.
// Emits one-cycle make/break events for the keyboard matrix block.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          flt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          fall_q;

    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          ext_q, brk_q;
    logic [2:0]    swallow_q;
    logic [TW-1:0] wdt_q;
    logic          strobe_q, pressed_q, extd_q, ferr_q;
    logic [7:0]    code_q;

    logic          timeout_d;

    assign key_strobe   = strobe_q;
    assign key_pressed  = pressed_q;
    assign key_code     = code_q;
    assign key_extended = extd_q;
    assign frame_error  = ferr_q;

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            flt_q     <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            fall_q   <= 1'b0;
            if (clk_s2_q == flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_q     <= clk_s2_q;
                flt_cnt_q <= '0;
                fall_q    <= flt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_d = (state_q != IDLE) && (state_q != DONE) && !fall_q &&
                       (wdt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            swallow_q <= '0;
            wdt_q     <= '0;
            strobe_q  <= 1'b0;
            pressed_q <= 1'b0;
            code_q    <= '0;
            extd_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            if (fall_q) begin
                wdt_q <= '0;
            end else if (state_q != IDLE) begin
                wdt_q <= wdt_q + 1'b1;
            end

            if (timeout_d) begin
                ferr_q  <= 1'b1;
                ext_q   <= 1'b0;
                brk_q   <= 1'b0;
                wdt_q   <= '0;
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (fall_q && !dat_s2_q) begin
                            bitcnt_q <= '0;
                            state_q  <= DATA;
                        end
                    end
                    DATA: begin
                        if (fall_q) begin
                            shift_q  <= {dat_s2_q, shift_q[7:1]};
                            bitcnt_q <= bitcnt_q + 1'b1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (fall_q) begin
                            par_q   <= dat_s2_q;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (fall_q) begin
                            if (dat_s2_q && (^{shift_q, par_q})) begin
                                state_q <= DONE;
                            end else begin
                                ferr_q    <= 1'b1;
                                ext_q     <= 1'b0;
                                brk_q     <= 1'b0;
                                swallow_q <= '0;
                                state_q   <= IDLE;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        if (swallow_q != 3'd0) begin
                            swallow_q <= swallow_q - 1'b1;
                        end else if (shift_q == 8'hE1) begin
                            // Pause sends 7 more bytes after E1; drop them all.
                            swallow_q <= 3'd7;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else if (shift_q == 8'h00 || shift_q == 8'hAA ||
                                     shift_q == 8'hEE || shift_q == 8'hFA ||
                                     shift_q == 8'hFC || shift_q == 8'hFD ||
                                     shift_q == 8'hFE || shift_q == 8'hFF) begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end else begin
                            strobe_q  <= 1'b1;
                            code_q    <= shift_q;
                            pressed_q <= ~brk_q;
                            extd_q    <= ext_q;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: PS/2 frame driver pushes expected
// events, a monitor pops and compares on every strobe or frame error.
module tb_ps2_key_decoder;

    localparam int FL = 8;
    localparam int TO = 1000;
    localparam int H  = 20;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe;
    logic       key_pressed;
    logic [7:0] key_code;
    logic       key_extended;
    logic       frame_error;

    ps2_key_decoder #(
        .FILTER_LEN(FL),
        .TIMEOUT   (TO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_strobe  (key_strobe),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .key_extended(key_extended),
        .frame_error (frame_error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       pressed;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_key(input logic [7:0] c, input logic p, input logic e);
        exp_q.push_back('{err: 1'b0, code: c, pressed: p, ext: e});
    endtask

    task automatic push_err();
        exp_q.push_back('{err: 1'b1, code: 8'h00, pressed: 1'b0, ext: 1'b0});
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && (key_strobe || frame_error)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event strobe=%b err=%b code=%h",
                         key_strobe, frame_error, key_code);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.err) begin
                    chk("frame_error", {30'd0, frame_error, key_strobe},
                        32'h2);
                end else begin
                    chk("key_event",
                        {21'd0, key_strobe, frame_error, key_code,
                         key_pressed, key_extended},
                        {21'd0, 1'b1, 1'b0, e.code, e.pressed, e.ext});
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk_sys);
    endtask

    task automatic partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i]);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        int         budget;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        repeat (4) @(negedge clk_sys);
        chk("rst_strobe", {31'd0, key_strobe}, 32'd0);
        chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
        chk("rst_code", {24'd0, key_code}, 32'd0);
        chk("rst_ext", {31'd0, key_extended}, 32'd0);
        chk("rst_ferr", {31'd0, frame_error}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);

        push_key(8'h1C, 1'b1, 1'b0);
        send(8'h1C, 1'b0);

        send(8'hF0, 1'b0);
        push_key(8'h1C, 1'b0, 1'b0);
        send(8'h1C, 1'b0);

        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        push_key(8'h75, 1'b0, 1'b1);
        send(8'h75, 1'b0);

        send(8'hF0, 1'b0);
        push_err();
        send(8'h29, 1'b1);
        push_key(8'h29, 1'b1, 1'b0);
        send(8'h29, 1'b0);

        for (int i = 0; i < 8; i++) send(pause_seq[i], 1'b0);
        push_key(8'h16, 1'b1, 1'b0);
        send(8'h16, 1'b0);

        push_err();
        partial(8'h5A, 4);
        ps2_data = 1'b1;
        repeat (TO + 200) @(negedge clk_sys);
        push_key(8'h5A, 1'b1, 1'b0);
        send(8'h5A, 1'b0);

        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (40) @(negedge clk_sys);
        push_key(8'h1C, 1'b1, 1'b0);
        send(8'h1C, 1'b0);

        send(8'hE0, 1'b0);
        send(8'hE0, 1'b0);
        push_key(8'h74, 1'b1, 1'b1);
        send(8'h74, 1'b0);

        send(8'hF0, 1'b0);
        send(8'hE0, 1'b0);
        push_key(8'h71, 1'b0, 1'b1);
        send(8'h71, 1'b0);

        send(8'hAA, 1'b0);
        send(8'hFA, 1'b0);
        push_key(8'h23, 1'b1, 1'b1 ^ 1'b1);
        send(8'h23, 1'b0);

        partial(8'h33, 4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {20'd0, key_strobe, key_pressed, key_code, key_extended,
             frame_error}, 32'd0);
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        repeat (10) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        push_key(8'h1B, 1'b1, 1'b0);
        send(8'h1B, 1'b0);

        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(negedge clk_sys);
            budget++;
        end
        repeat (50) @(negedge clk_sys);
        chk("drain_pending", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
